// File: rtl/phase_accumulator_scheduler.sv
// Shares one external WIDTH-bit adder across NUM_VOICES oscillator phases.
// Each sample_tick starts a sweep that updates the voices in index order.
module phase_accumulator_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_BITS = 3,
    parameter int WIDTH      = 37
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] voice_enable,
    input  logic                  incr_wr_en,
    input  logic [VOICE_BITS-1:0] incr_wr_addr,
    input  logic [WIDTH-1:0]      incr_wr_data,
    input  logic                  overrun_clr,
    output logic [WIDTH-1:0]      adder_a,
    output logic [WIDTH-1:0]      adder_b,
    output logic                  adder_c_in,
    input  logic [WIDTH-1:0]      adder_sum,
    input  logic                  adder_c_out,
    output logic [WIDTH-1:0]      phase_out,
    output logic [VOICE_BITS-1:0] phase_voice,
    output logic                  phase_valid,
    output logic                  phase_wrap,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [VOICE_BITS-1:0]   voice_idx_q, voice_idx_d;
    logic [WIDTH-1:0]        phase_q [NUM_VOICES];
    logic [WIDTH-1:0]        phase_d [NUM_VOICES];
    logic [WIDTH-1:0]        incr_q  [NUM_VOICES];
    logic [WIDTH-1:0]        incr_d  [NUM_VOICES];
    logic [WIDTH-1:0]        phase_out_q, phase_out_d;
    logic [VOICE_BITS-1:0]   phase_voice_q, phase_voice_d;
    logic                    phase_valid_q, phase_valid_d;
    logic                    phase_wrap_q, phase_wrap_d;
    logic                    overrun_q, overrun_d;
    logic                    running;
    logic                    last_voice;
    logic                    voice_en;

    assign running    = (state_q == RUN);
    assign last_voice = (voice_idx_q == VOICE_BITS'(NUM_VOICES - 1));
    assign voice_en   = voice_enable[voice_idx_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            voice_idx_q   <= '0;
            phase_out_q   <= '0;
            phase_voice_q <= '0;
            phase_valid_q <= 1'b0;
            phase_wrap_q  <= 1'b0;
            overrun_q     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                incr_q[v]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            voice_idx_q   <= voice_idx_d;
            phase_out_q   <= phase_out_d;
            phase_voice_q <= phase_voice_d;
            phase_valid_q <= phase_valid_d;
            phase_wrap_q  <= phase_wrap_d;
            overrun_q     <= overrun_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                incr_q[v]  <= incr_d[v];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        voice_idx_d = voice_idx_q;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d     = RUN;
                    voice_idx_d = '0;
                end
            end
            RUN: begin
                if (last_voice) begin
                    state_d     = IDLE;
                    voice_idx_d = '0;
                end else begin
                    voice_idx_d = voice_idx_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                voice_idx_d = '0;
            end
        endcase
    end

    // The add this cycle reads incr_q, so a write to the active voice only lands next sweep.
    always_comb begin
        phase_d       = phase_q;
        incr_d        = incr_q;
        phase_out_d   = phase_out_q;
        phase_voice_d = phase_voice_q;
        phase_valid_d = 1'b0;
        phase_wrap_d  = 1'b0;
        overrun_d     = overrun_q;
        if (running) begin
            phase_d[voice_idx_q] = adder_sum;
            phase_out_d          = adder_sum;
            phase_voice_d        = voice_idx_q;
            phase_valid_d        = 1'b1;
            phase_wrap_d         = adder_c_out & voice_en;
        end
        if (incr_wr_en && (int'(incr_wr_addr) < NUM_VOICES)) begin
            incr_d[incr_wr_addr] = incr_wr_data;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (running && sample_tick) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        adder_a     = '0;
        adder_b     = '0;
        adder_c_in  = 1'b0;
        busy        = running;
        phase_out   = phase_out_q;
        phase_voice = phase_voice_q;
        phase_valid = phase_valid_q;
        phase_wrap  = phase_wrap_q;
        overrun     = overrun_q;
        if (running) begin
            adder_a = phase_q[voice_idx_q];
            if (voice_en) begin
                adder_b = incr_q[voice_idx_q];
            end
        end
    end

endmodule
